// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and error read data for the memory bus decoder
package bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, ERR = 2'd3} state_t;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/bus_timeout.sv
// bus_timeout: BUSY-cycle counter that flags the last cycle before the error response
module bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] cnt;
  assign expired = cnt == 16'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!resetn || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: routes one initiator request to a region-selected target and returns its response
module mem_bus_decoder
  import bus_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int TIMEOUT     = 255,
  parameter int SEL_LSB     = 28
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cpu_valid,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [3:0]                cpu_wstrb,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [NUM_TARGETS-1:0]    tgt_valid,
  output logic [31:0]               tgt_addr,
  output logic [31:0]               tgt_wdata,
  output logic [3:0]                tgt_wstrb,
  input  logic [32*NUM_TARGETS-1:0] tgt_rdata,
  input  logic [NUM_TARGETS-1:0]    tgt_ready
);
  localparam int SW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
  localparam logic [4:0] NT = 5'(NUM_TARGETS);
  state_t state, next;
  logic [SW-1:0] sel;
  logic [3:0] region;
  logic accept, mapped, rdy, expired;
  assign region = cpu_addr[SEL_LSB+3:SEL_LSB];
  assign accept = state == IDLE && cpu_valid;
  assign mapped = {1'b0, region} < NT;
  assign rdy = state == BUSY && tgt_ready[sel];
  assign tgt_valid = state == BUSY ? NUM_TARGETS'(1) << sel : '0;
  assign cpu_ready = state == RESP || state == ERR;
  assign cpu_err = state == ERR;
  always_comb begin
    next = state;
    next = state == IDLE ? (cpu_valid ? (mapped ? BUSY : ERR) : IDLE)
         : state == BUSY ? (tgt_ready[sel] ? RESP : expired ? ERR : BUSY)
         : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      sel       <= '0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_wstrb <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= next;
      if (accept) begin
        tgt_addr  <= cpu_addr;
        tgt_wdata <= cpu_wdata;
        tgt_wstrb <= cpu_wstrb;
      end
      if (accept && mapped) sel <= region[SW-1:0];
      if (rdy) cpu_rdata <= tgt_rdata[{sel, 5'd0} +: 32];
      else if (next == ERR) cpu_rdata <= ERR_RDATA;
    end
  end
  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (accept && mapped),
    .enable (state == BUSY),
    .expired(expired)
  );
endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: directed vectors with hand-computed expectations for mem_bus_decoder
module tb_mem_bus_decoder;
  logic clk = 1'b0;
  logic resetn;
  logic cpu_valid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0] cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic cpu_ready, cpu_err;
  logic [3:0] tgt_valid;
  logic [31:0] tgt_addr, tgt_wdata;
  logic [3:0] tgt_wstrb;
  logic [127:0] tgt_rdata;
  logic [3:0] tgt_ready;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  mem_bus_decoder #(.NUM_TARGETS(4), .TIMEOUT(8), .SEL_LSB(28)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .tgt_valid(tgt_valid), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_wstrb(tgt_wstrb),
    .tgt_rdata(tgt_rdata), .tgt_ready(tgt_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wstrb = s;
  endtask
  task automatic resp(input string tag, input logic err, input logic [31:0] rd);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    chk({tag, "_err"}, 32'(cpu_err), 32'(err));
    chk({tag, "_rdata"}, cpu_rdata, rd);
    chk({tag, "_valid"}, 32'(tgt_valid), 32'd0);
  endtask
  initial begin
    resetn = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    tgt_rdata = '0; tgt_ready = '0;
    tick; tick;
    chk("rst_valid", 32'(tgt_valid), 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", tgt_addr, 32'd0);
    resetn = 1'b1;
    tick;
    // read target 1, ready at cycle 3
    req(32'h1000_0010, 32'h0, 4'b0000);
    tgt_rdata[63:32] = 32'hDEAD_BEEF;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("rd_valid", 32'(tgt_valid), 32'h2);
      chk("rd_busy_ready", 32'(cpu_ready), 32'd0);
    end
    chk("rd_addr", tgt_addr, 32'h1000_0010);
    chk("rd_wstrb", 32'(tgt_wstrb), 32'd0);
    tgt_ready = 4'b0010;
    tick;
    resp("rd", 1'b0, 32'hDEAD_BEEF);
    cpu_valid = 1'b0; tgt_ready = '0;
    tick;
    chk("rd_idle_ready", 32'(cpu_ready), 32'd0);
    // write target 2, ready at cycle 1; request changes must not leak through
    req(32'h2000_0004, 32'h1234_5678, 4'b1111);
    tgt_rdata[95:64] = 32'h0BAD_F00D;
    tick;
    chk("wr_valid", 32'(tgt_valid), 32'h4);
    chk("wr_wdata", tgt_wdata, 32'h1234_5678);
    chk("wr_wstrb", 32'(tgt_wstrb), 32'hF);
    chk("wr_addr", tgt_addr, 32'h2000_0004);
    cpu_wdata = 32'hAAAA_AAAA; cpu_wstrb = 4'b0001;
    tgt_ready = 4'b0100;
    tick;
    resp("wr", 1'b0, 32'h0BAD_F00D);
    chk("wr_hold_wdata", tgt_wdata, 32'h1234_5678);
    cpu_valid = 1'b0; tgt_ready = '0;
    tick;
    // unmapped region
    req(32'h7000_0000, 32'h0, 4'b0000);
    tick;
    resp("unm", 1'b1, 32'hFFFF_FFFF);
    cpu_valid = 1'b0;
    tick;
    chk("unm_after_ready", 32'(cpu_ready), 32'd0);
    chk("unm_after_err", 32'(cpu_err), 32'd0);
    // target 0 never ready: 8 BUSY cycles then error; cpu_valid drop is ignored
    req(32'h0000_0000, 32'h0, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 1) cpu_valid = 1'b0;
      chk("to_valid", 32'(tgt_valid), 32'h1);
    end
    tick;
    resp("to", 1'b1, 32'hFFFF_FFFF);
    tick;
    chk("to_idle_ready", 32'(cpu_ready), 32'd0);
    // ready on the 8th BUSY cycle wins over timeout
    req(32'h0000_0000, 32'h0, 4'b0000);
    tgt_rdata[31:0] = 32'hCAFE_0000;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("tor_valid", 32'(tgt_valid), 32'h1);
    end
    tgt_ready = 4'b0001;
    tick;
    resp("tor", 1'b0, 32'hCAFE_0000);
    cpu_valid = 1'b0; tgt_ready = '0;
    tick;
    // target 3 ready while target 1 selected, then reset in BUSY cycle 2
    req(32'h1000_0000, 32'h0, 4'b0000);
    tick;
    tgt_ready = 4'b1000;
    tick;
    chk("ns_valid", 32'(tgt_valid), 32'h2);
    chk("ns_ready", 32'(cpu_ready), 32'd0);
    resetn = 1'b0;
    tick;
    chk("mrst_valid", 32'(tgt_valid), 32'd0);
    chk("mrst_ready", 32'(cpu_ready), 32'd0);
    chk("mrst_err", 32'(cpu_err), 32'd0);
    chk("mrst_rdata", cpu_rdata, 32'd0);
    chk("mrst_addr", tgt_addr, 32'd0);
    resetn = 1'b1; cpu_valid = 1'b0; tgt_ready = '0;
    tick;
    chk("mrst_idle", 32'(cpu_ready), 32'd0);
    req(32'h2000_0008, 32'h0, 4'b0000);
    tgt_rdata[95:64] = 32'h55AA_55AA;
    tick;
    chk("fresh_valid", 32'(tgt_valid), 32'h4);
    tgt_ready = 4'b0100;
    tick;
    resp("fresh", 1'b0, 32'h55AA_55AA);
    cpu_valid = 1'b0; tgt_ready = '0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
